// File: rtl/kbd_text_pkg.sv
// Shared types and constants for the keyboard text buffer: FSM states,
// PS/2 set-2 control scancodes and the blank-cell character.
package kbd_text_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_EXT   = 2'd2,
    ST_BREAK = 2'd3
  } kbd_state_t;

  localparam logic [7:0] SC_EXT      = 8'hE0;
  localparam logic [7:0] SC_BREAK    = 8'hF0;
  localparam logic [7:0] SC_BKSP     = 8'h66;
  localparam logic [7:0] SC_ENTER    = 8'h5A;
  localparam logic [7:0] SC_ESC      = 8'h76;
  localparam logic [7:0] SC_LSHIFT   = 8'h12;
  localparam logic [7:0] SC_RSHIFT   = 8'h59;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  // Row-major cell index shared by the write and read address paths.
  function automatic int unsigned cell_index(input int unsigned row,
                                             input int unsigned col,
                                             input int unsigned cols);
    return row * cols + col;
  endfunction

endpackage

// File: rtl/kbd_text_buffer_ascii.sv
// Combinational PS/2 set-2 make-code to ASCII lookup.
// With KBD_TEXT_SHIFT_EN letters are lowercase unless shift is held.
module ps2_set2_to_ascii
  import kbd_text_pkg::*;
(
  input  logic [7:0] code,
  input  logic       shift,
  output logic [7:0] ascii,
  output logic       hit
);

  logic [7:0] w_letter;

  always_comb begin
    ascii    = 8'h00;
    hit      = 1'b1;
    w_letter = 8'h00;
    case (code)
      8'h1C: w_letter = "A";
      8'h32: w_letter = "B";
      8'h21: w_letter = "C";
      8'h23: w_letter = "D";
      8'h24: w_letter = "E";
      8'h2B: w_letter = "F";
      8'h34: w_letter = "G";
      8'h33: w_letter = "H";
      8'h43: w_letter = "I";
      8'h3B: w_letter = "J";
      8'h42: w_letter = "K";
      8'h4B: w_letter = "L";
      8'h3A: w_letter = "M";
      8'h31: w_letter = "N";
      8'h44: w_letter = "O";
      8'h4D: w_letter = "P";
      8'h15: w_letter = "Q";
      8'h2D: w_letter = "R";
      8'h1B: w_letter = "S";
      8'h2C: w_letter = "T";
      8'h3C: w_letter = "U";
      8'h2A: w_letter = "V";
      8'h1D: w_letter = "W";
      8'h22: w_letter = "X";
      8'h35: w_letter = "Y";
      8'h1A: w_letter = "Z";
      8'h16: ascii = shift ? "!" : "1";
      8'h1E: ascii = shift ? "@" : "2";
      8'h26: ascii = shift ? "#" : "3";
      8'h25: ascii = shift ? "$" : "4";
      8'h2E: ascii = shift ? "%" : "5";
      8'h36: ascii = shift ? "^" : "6";
      8'h3D: ascii = shift ? "&" : "7";
      8'h3E: ascii = shift ? "*" : "8";
      8'h46: ascii = shift ? "(" : "9";
      8'h45: ascii = shift ? ")" : "0";
      8'h29: ascii = ASCII_SPACE;
      8'h41: ascii = shift ? "<" : ",";
      8'h49: ascii = shift ? ">" : ".";
      8'h4E: ascii = shift ? "_" : "-";
      default: hit = 1'b0;
    endcase
    if (w_letter != 8'h00) begin
`ifdef KBD_TEXT_SHIFT_EN
      ascii = shift ? w_letter : (w_letter | 8'h20);
`else
      ascii = w_letter;
`endif
    end
  end

endmodule

// File: rtl/kbd_text_buffer.sv
// Scancode-driven COLS x ROWS text buffer with cursor and BS/Enter/Esc editing.
// Optional shift tracking is enabled by defining KBD_TEXT_SHIFT_EN.
module kbd_text_buffer
  import kbd_text_pkg::*;
#(
  parameter int COLS = 80,
  parameter int ROWS = 30,
  parameter int CW   = $clog2(COLS),
  parameter int RW   = ($clog2(ROWS) > 0) ? $clog2(ROWS) : 1
) (
  input  logic          mclk,
  input  logic          reset,
  input  logic [7:0]    code_in,
  input  logic          code_valid,
  input  logic [CW-1:0] rd_col,
  input  logic [RW-1:0] rd_row,
  output logic [7:0]    rd_char,
  output logic [CW-1:0] cursor_col,
  output logic [RW-1:0] cursor_row,
  output logic          busy,
  output logic [7:0]    ascii_out,
  output logic          ascii_valid,
  output kbd_state_t    dbg_state
);

  localparam int CELLS = COLS * ROWS;
  localparam int AW    = $clog2(CELLS);
  localparam logic [CW-1:0] LAST_COL  = CW'(COLS - 1);
  localparam logic [RW-1:0] LAST_ROW  = RW'(ROWS - 1);
  localparam logic [AW-1:0] LAST_CELL = AW'(CELLS - 1);

  kbd_state_t    r_state;
  logic [AW-1:0] r_clr_ptr;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic          r_busy;
  logic [7:0]    r_ascii;
  logic          r_ascii_valid;
  logic [7:0]    r_rd_char;
  logic [7:0]    r_mem [0:CELLS-1];

  logic [7:0]    w_lut_ascii;
  logic          w_lut_hit;
  logic          w_shift;
  logic          w_make;
  logic          w_col_last;
  logic [RW-1:0] w_nl_row;
  logic [CW-1:0] w_next_col;
  logic [RW-1:0] w_next_row;
  logic [CW-1:0] w_prev_col;
  logic [RW-1:0] w_prev_row;
  logic          w_at_origin;
  logic [AW-1:0] w_cur_addr;
  logic [AW-1:0] w_prev_addr;
  logic [AW-1:0] w_raddr;
  logic          w_rd_ok;
  logic          w_we;
  logic [AW-1:0] w_waddr;
  logic [7:0]    w_wdata;

  ps2_set2_to_ascii u_lut (
    .code  (code_in),
    .shift (w_shift),
    .ascii (w_lut_ascii),
    .hit   (w_lut_hit)
  );

`ifdef KBD_TEXT_SHIFT_EN
  logic r_shift;
  logic w_is_shift_code;
  assign w_is_shift_code = (code_in == SC_LSHIFT) || (code_in == SC_RSHIFT);

  // Shift make only counts from IDLE; its release arrives through BREAK.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      r_shift <= 1'b0;
    end else if (code_valid && w_is_shift_code) begin
      if (r_state == ST_IDLE)       r_shift <= 1'b1;
      else if (r_state == ST_BREAK) r_shift <= 1'b0;
    end
  end
  assign w_shift = r_shift;
`else
  assign w_shift = 1'b0;
`endif

  assign w_make = code_valid && (r_state == ST_IDLE) &&
                  (code_in != SC_EXT) && (code_in != SC_BREAK);

  // Cursor neighbours: advance, newline and backspace targets.
  assign w_col_last  = (r_col == LAST_COL);
  assign w_nl_row    = (r_row == LAST_ROW) ? '0 : r_row + RW'(1);
  assign w_next_col  = w_col_last ? '0 : r_col + CW'(1);
  assign w_next_row  = w_col_last ? w_nl_row : r_row;
  assign w_at_origin = (r_col == '0) && (r_row == '0);
  assign w_prev_col  = (r_col == '0) ? LAST_COL : r_col - CW'(1);
  assign w_prev_row  = (r_col == '0) ? r_row - RW'(1) : r_row;

  assign w_cur_addr  = AW'(cell_index(32'(r_row), 32'(r_col), COLS));
  assign w_prev_addr = AW'(cell_index(32'(w_prev_row), 32'(w_prev_col), COLS));
  assign w_raddr     = AW'(cell_index(32'(rd_row), 32'(rd_col), COLS));
  assign w_rd_ok     = (32'(rd_col) < COLS) && (32'(rd_row) < ROWS);

  always_comb begin
    w_we    = 1'b0;
    w_waddr = w_cur_addr;
    w_wdata = ASCII_SPACE;
    if (r_state == ST_CLEAR) begin
      w_we    = 1'b1;
      w_waddr = r_clr_ptr;
    end else if (w_make) begin
      if (code_in == SC_BKSP) begin
        w_we    = !w_at_origin;
        w_waddr = w_prev_addr;
      end else if (w_lut_hit) begin
        w_we    = 1'b1;
        w_wdata = w_lut_ascii;
      end
    end
  end

  always_ff @(posedge mclk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  // Read-before-write: a same-cycle write to the read cell returns old data.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) r_rd_char <= ASCII_SPACE;
    else       r_rd_char <= w_rd_ok ? r_mem[w_raddr] : ASCII_SPACE;
  end

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_CLEAR;
      r_clr_ptr     <= '0;
      r_col         <= '0;
      r_row         <= '0;
      r_busy        <= 1'b1;
      r_ascii       <= 8'h00;
      r_ascii_valid <= 1'b0;
    end else begin
      r_ascii_valid <= 1'b0;
      case (r_state)
        ST_CLEAR: begin
          r_clr_ptr <= r_clr_ptr + AW'(1);
          if (r_clr_ptr == LAST_CELL) begin
            r_clr_ptr <= '0;
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (code_valid) begin
            if (code_in == SC_EXT) begin
              r_state <= ST_EXT;
            end else if (code_in == SC_BREAK) begin
              r_state <= ST_BREAK;
            end else if (code_in == SC_ESC) begin
              r_col     <= '0;
              r_row     <= '0;
              r_clr_ptr <= '0;
              r_busy    <= 1'b1;
              r_state   <= ST_CLEAR;
            end else if (code_in == SC_ENTER) begin
              r_col <= '0;
              r_row <= w_nl_row;
            end else if (code_in == SC_BKSP) begin
              if (!w_at_origin) begin
                r_col <= w_prev_col;
                r_row <= w_prev_row;
              end
            end else if (w_lut_hit) begin
              r_col         <= w_next_col;
              r_row         <= w_next_row;
              r_ascii       <= w_lut_ascii;
              r_ascii_valid <= 1'b1;
            end
          end
        end
        ST_EXT: begin
          if (code_valid) r_state <= (code_in == SC_BREAK) ? ST_BREAK : ST_IDLE;
        end
        ST_BREAK: begin
          if (code_valid) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rd_char     = r_rd_char;
  assign cursor_col  = r_col;
  assign cursor_row  = r_row;
  assign busy        = r_busy;
  assign ascii_out   = r_ascii;
  assign ascii_valid = r_ascii_valid;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_kbd_text_buffer.sv
// Bench for kbd_text_buffer with a 4x2 buffer; ASCII output is scoreboarded.
module tb_kbd_text_buffer;
  import kbd_text_pkg::*;

  localparam int COLS = 4;
  localparam int ROWS = 2;
  localparam int CW   = 2;
  localparam int RW   = 1;

  // clock / reset
  logic          mclk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    code_in = 8'h00;
  logic          code_valid = 1'b0;
  logic [CW-1:0] rd_col = '0;
  logic [RW-1:0] rd_row = '0;
  logic [7:0]    rd_char;
  logic [CW-1:0] cursor_col;
  logic [RW-1:0] cursor_row;
  logic          busy;
  logic [7:0]    ascii_out;
  logic          ascii_valid;
  kbd_state_t    dbg_state;

  always #5 mclk = ~mclk;

  kbd_text_buffer #(.COLS(COLS), .ROWS(ROWS)) dut (
    .mclk        (mclk),
    .reset       (reset),
    .code_in     (code_in),
    .code_valid  (code_valid),
    .rd_col      (rd_col),
    .rd_row      (rd_row),
    .rd_char     (rd_char),
    .cursor_col  (cursor_col),
    .cursor_row  (cursor_row),
    .busy        (busy),
    .ascii_out   (ascii_out),
    .ascii_valid (ascii_valid),
    .dbg_state   (dbg_state)
  );

  // scoreboard
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] text [8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge mclk) begin
    if (ascii_valid === 1'b1) begin
      if (exp_q.size() == 0) check("ascii_unexpected", ascii_valid, 1'b0);
      else                   check("ascii_out", ascii_out, exp_q.pop_front());
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic send(input logic [7:0] c);
    code_in    = c;
    code_valid = 1'b1;
    tick();
    code_valid = 1'b0;
  endtask

  task automatic send_char(input logic [7:0] c, input logic [7:0] a);
    exp_q.push_back(a);
    send(c);
  endtask

  task automatic check_cell(input string tag, input int col, input int row, input logic [7:0] e);
    rd_col = CW'(col);
    rd_row = RW'(row);
    tick();
    check(tag, rd_char, e);
  endtask

  task automatic check_cursor(input string tag, input int col, input int row);
    check({tag, "_col"}, cursor_col, col);
    check({tag, "_row"}, cursor_row, row);
  endtask

  task automatic check_blank(input string tag);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        check_cell(tag, c, r, 8'h20);
  endtask

  task automatic wait_clear(input string tag, input logic drive_codes);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      if (drive_codes) begin
        code_in    = 8'h1C;
        code_valid = 1'b1;
      end
      tick();
      n++;
    end
    code_valid = 1'b0;
    check(tag, n, 8);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tick();
    tick();
    check("rst_busy", busy, 1'b1);
    check("rst_state", dbg_state, ST_CLEAR);
    check_cursor("rst", 0, 0);
    check("rst_ascii_out", ascii_out, 8'h00);
    check("rst_ascii_valid", ascii_valid, 1'b0);
    check("rst_rd_char", rd_char, 8'h20);
    reset = 1'b0;
    wait_clear("rst_busy_cycles", 1'b0);
    check_blank("rst_blank");
    check_cursor("rst_done", 0, 0);

    // printable make, then its release
    send_char(8'h1C, "A");
    check_cursor("first_char", 1, 0);
    check_cell("cell_0_0", 0, 0, "A");
    send(8'hF0);
    send(8'h1C);
    check_cursor("release", 1, 0);
    check("release_state", dbg_state, ST_IDLE);
    check("release_ascii", ascii_out, "A");

    // cursor wrap across rows and back to origin
    send_char(8'h32, "B");
    send_char(8'h21, "C");
    send_char(8'h23, "D");
    check_cursor("row_wrap", 0, 1);
    send_char(8'h24, "E");
    check_cursor("fifth", 1, 1);
    send_char(8'h2B, "F");
    send_char(8'h34, "G");
    send_char(8'h33, "H");
    check_cursor("full_wrap", 0, 0);
    text = '{"A", "B", "C", "D", "E", "F", "G", "H"};
    for (int i = 0; i < 8; i++) check_cell("text", i % COLS, i / COLS, text[i]);

    // backspace / enter
    send(8'h66);
    check_cursor("bs_origin", 0, 0);
    check_cell("bs_origin_cell", 0, 0, "A");
    send(8'h5A);
    check_cursor("enter", 0, 1);
    check_cell("enter_nowrite", 0, 1, "E");
    send(8'h66);
    check_cursor("bs_wrap", 3, 0);
    check_cell("bs_cell", 3, 0, 8'h20);

    // typematic repeat, unmapped code, enter wrap on last row
    send_char(8'h1C, "A");
    send_char(8'h1C, "A");
    check_cursor("typematic", 1, 1);
    check_cell("typematic_a", 3, 0, "A");
    check_cell("typematic_b", 0, 1, "A");
    send(8'h05);
    check_cursor("unmapped", 1, 1);
    send(8'h5A);
    check_cursor("enter_wrap", 0, 0);

    // escape clear with codes dropped while busy
    send_char(8'h29, 8'h20);
    send(8'h76);
    check("esc_busy", busy, 1'b1);
    check("esc_state", dbg_state, ST_CLEAR);
    check_cursor("esc", 0, 0);
    wait_clear("esc_busy_cycles", 1'b1);
    check_blank("esc_blank");
    check_cursor("esc_done", 0, 0);
    send(8'hE0);
    send(8'h75);
    check_cursor("ext_ignored", 0, 0);
    check("ext_state", dbg_state, ST_IDLE);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    check("ext_break_state", dbg_state, ST_IDLE);
    check_cell("ext_cell", 0, 0, 8'h20);

`ifdef KBD_TEXT_SHIFT_EN
    send(8'h12);
    send_char(8'h1C, "A");
    send(8'hF0);
    send(8'h12);
    send_char(8'h1C, "a");
    send(8'h59);
    send_char(8'h16, "!");
    send(8'hF0);
    send(8'h59);
    send_char(8'h16, "1");
    check_cursor("shift", 0, 1);
    text[0:3] = '{"A", "a", "!", "1"};
`else
    send(8'h12);
    check_cursor("shift_ignored", 0, 0);
    send_char(8'h1C, "A");
    send_char(8'h16, "1");
    send(8'h59);
    send_char(8'h1E, "2");
    check_cursor("noshift", 3, 0);
    text[0:3] = '{"A", "1", "2", 8'h20};
`endif
    for (int i = 0; i < 4; i++) check_cell("shift_text", i, 0, text[i]);

    // reset mid-operation aborts a pending break prefix
    send(8'hF0);
    reset = 1'b1;
    #2;
    check("mid_rst_busy", busy, 1'b1);
    check("mid_rst_state", dbg_state, ST_CLEAR);
    check_cursor("mid_rst", 0, 0);
    check("mid_rst_ascii", ascii_out, 8'h00);
    tick();
    reset = 1'b0;
    wait_clear("mid_rst_busy_cycles", 1'b0);
`ifdef KBD_TEXT_SHIFT_EN
    send_char(8'h1C, "a");
    check_cell("after_rst_cell", 0, 0, "a");
`else
    send_char(8'h1C, "A");
    check_cell("after_rst_cell", 0, 0, "A");
`endif
    check_cursor("after_rst", 1, 0);

    tick();
    tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
